// File: rtl/mem_arbiter.sv
// Arbitrates instruction fetch and data accesses onto one single-ported RAM.
// Data has fixed priority over fetch, and a watchdog bounds every granted access.
module mem_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned WORD_W  = 32,
   parameter int unsigned TIMEOUT = 64
) (
   input  logic              CLK,
   input  logic              nRST,
   input  logic              iREN,
   input  logic [ADDR_W-1:0] iaddr,
   output logic [WORD_W-1:0] iload,
   output logic              iwait,
   input  logic              dREN,
   input  logic              dWEN,
   input  logic [ADDR_W-1:0] daddr,
   input  logic [WORD_W-1:0] dstore,
   output logic [WORD_W-1:0] dload,
   output logic              dwait,
   output logic              ramREN,
   output logic              ramWEN,
   output logic [ADDR_W-1:0] ramaddr,
   output logic [WORD_W-1:0] ramstore,
   input  logic [WORD_W-1:0] ramload,
   input  logic              ramready,
   output logic              err
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] DATA  = 2'd1;
   localparam logic [1:0] INSTR = 2'd2;

   localparam logic [WORD_W-1:0] BAD_WORD = WORD_W'(32'hBAD1BAD1);
   localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic [1:0]       next_state;
   logic [CNT_W-1:0] cnt;
   logic             expire;

   // State, watchdog counter and sticky timeout flag
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state <= IDLE;
         cnt   <= '0;
         err   <= 1'b0;
      end else begin
         state <= next_state;
         if (state == IDLE) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
         if (expire) begin
            err <= 1'b1;
         end
      end
   end

   // Grant decode, RAM steering and completion/abort/timeout handling
   always_comb begin
      next_state = state;
      iwait      = 1'b1;
      dwait      = 1'b1;
      iload      = '0;
      dload      = '0;
      ramREN     = 1'b0;
      ramWEN     = 1'b0;
      ramaddr    = '0;
      ramstore   = '0;
      expire     = 1'b0;

      case (state)
         IDLE: begin
            if (dREN || dWEN) begin
               next_state = DATA;
            end else if (iREN) begin
               next_state = INSTR;
            end
         end

         DATA: begin
            ramaddr  = daddr;
            ramstore = dstore;
            ramWEN   = dWEN;
            ramREN   = dREN & ~dWEN;
            dload    = ramload;
            // A dropped request aborts silently; enables already follow the inputs
            if (!(dREN || dWEN)) begin
               next_state = IDLE;
            end else if (ramready) begin
               dwait      = 1'b0;
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               dwait      = 1'b0;
               dload      = BAD_WORD;
               expire     = 1'b1;
               next_state = IDLE;
            end
         end

         INSTR: begin
            ramaddr = iaddr;
            ramREN  = iREN;
            iload   = ramload;
            if (!iREN) begin
               next_state = IDLE;
            end else if (ramready) begin
               iwait      = 1'b0;
               next_state = IDLE;
            end else if (cnt == CNT_LAST) begin
               iwait      = 1'b0;
               iload      = BAD_WORD;
               expire     = 1'b1;
               next_state = IDLE;
            end
         end

         default: begin
            next_state = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed and randomized check of mem_arbiter against a per-transaction timeline model.
module tb_mem_arbiter;

   localparam int TIMEOUT = 8;
   localparam logic [31:0] BAD = 32'hBAD1BAD1;

   logic        CLK;
   logic        nRST;
   logic        iREN;
   logic [31:0] iaddr;
   logic [31:0] iload;
   logic        iwait;
   logic        dREN;
   logic        dWEN;
   logic [31:0] daddr;
   logic [31:0] dstore;
   logic [31:0] dload;
   logic        dwait;
   logic        ramREN;
   logic        ramWEN;
   logic [31:0] ramaddr;
   logic [31:0] ramstore;
   logic [31:0] ramload;
   logic        ramready;
   logic        err;

   int   checks   = 0;
   int   failures = 0;
   logic err_m    = 1'b0;

   mem_arbiter #(.ADDR_W(32), .WORD_W(32), .TIMEOUT(TIMEOUT)) dut (
      .CLK(CLK), .nRST(nRST),
      .iREN(iREN), .iaddr(iaddr), .iload(iload), .iwait(iwait),
      .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
      .dload(dload), .dwait(dwait),
      .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
      .ramload(ramload), .ramready(ramready), .err(err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Outputs every arbiter should show with nothing granted (idle or in reset)
   task automatic chk_quiet(input string tag);
      chk1({tag, "_ren"}, ramREN, 1'b0);
      chk1({tag, "_wen"}, ramWEN, 1'b0);
      chk32({tag, "_addr"}, ramaddr, 32'h0);
      chk32({tag, "_store"}, ramstore, 32'h0);
      chk1({tag, "_iwait"}, iwait, 1'b1);
      chk1({tag, "_dwait"}, dwait, 1'b1);
      chk32({tag, "_iload"}, iload, 32'h0);
      chk32({tag, "_dload"}, dload, 32'h0);
      chk1({tag, "_err"}, err, err_m);
   endtask

   // One arbitration cycle; a stray ramready here must be ignored
   task automatic idle_cycle();
      ramready = 1'($urandom);
      ramload  = $urandom;
      @(negedge CLK);
      chk_quiet("idle");
      @(posedge CLK); #1;
      ramready = 1'b0;
   endtask

   // Granted cycles of one access; the RAM answers on cycle lat (never if lat > TIMEOUT)
   task automatic grant_cycles(input bit is_data, input int lat, input logic [31:0] rdata);
      bit          rdy;
      bit          to;
      logic [31:0] ld;
      for (int k = 1; k <= TIMEOUT; k++) begin
         rdy      = (k == lat);
         to       = !rdy && (k == TIMEOUT);
         ramready = rdy;
         ramload  = rdy ? rdata : $urandom;
         ld       = to ? BAD : ramload;
         @(negedge CLK);
         if (is_data) begin
            chk1("d_wen", ramWEN, dWEN);
            chk1("d_ren", ramREN, dREN & ~dWEN);
            chk32("d_addr", ramaddr, daddr);
            chk32("d_store", ramstore, dstore);
            chk1("d_wait", dwait, !(rdy || to));
            chk32("d_load", dload, ld);
            chk1("d_iwait", iwait, 1'b1);
            chk32("d_iload", iload, 32'h0);
         end else begin
            chk1("i_ren", ramREN, 1'b1);
            chk1("i_wen", ramWEN, 1'b0);
            chk32("i_addr", ramaddr, iaddr);
            chk32("i_store", ramstore, 32'h0);
            chk1("i_wait", iwait, !(rdy || to));
            chk32("i_load", iload, ld);
            chk1("i_dwait", dwait, 1'b1);
            chk32("i_dload", dload, 32'h0);
         end
         chk1("g_err", err, err_m);
         @(posedge CLK); #1;
         if (to) err_m = 1'b1;
         if (rdy || to) begin
            ramready = 1'b0;
            if (is_data) begin
               dREN = 1'b0;
               dWEN = 1'b0;
            end else begin
               iREN = 1'b0;
            end
            break;
         end
      end
   endtask

   initial begin
      logic [2:0] r;
      int         lat_d;
      int         lat_i;

      nRST = 1'b0; iREN = 1'b0; dREN = 1'b0; dWEN = 1'b0;
      iaddr = '0; daddr = '0; dstore = '0; ramload = '0; ramready = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      chk_quiet("rst");
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK); #1;

      // Lone fetch, zero-wait RAM
      iREN = 1'b1; iaddr = 32'h40;
      idle_cycle();
      grant_cycles(1'b0, 1, 32'h8C220004);
      idle_cycle();

      // Write and fetch together: data first, one idle cycle, then the fetch
      iREN = 1'b1; iaddr = 32'h44;
      dWEN = 1'b1; daddr = 32'h100; dstore = 32'hDEADBEEF;
      idle_cycle();
      grant_cycles(1'b1, 3, 32'h0);
      idle_cycle();
      grant_cycles(1'b0, 1, 32'h12345678);

      // Read and write together: write wins
      dREN = 1'b1; dWEN = 1'b1; daddr = 32'h104; dstore = 32'h0BADF00D;
      idle_cycle();
      grant_cycles(1'b1, 2, 32'h0);

      // Read abandoned in its 2nd granted cycle
      dREN = 1'b1; daddr = 32'h200;
      idle_cycle();
      ramready = 1'b0;
      @(negedge CLK);
      chk1("ab_ren1", ramREN, 1'b1);
      chk1("ab_dwait1", dwait, 1'b1);
      @(posedge CLK); #1;
      dREN = 1'b0;
      @(negedge CLK);
      chk1("ab_ren2", ramREN, 1'b0);
      chk1("ab_dwait2", dwait, 1'b1);
      @(posedge CLK); #1;
      idle_cycle();

      // RAM answers exactly at the watchdog limit: real data, no error
      dREN = 1'b1; daddr = 32'h300;
      idle_cycle();
      grant_cycles(1'b1, TIMEOUT, 32'hCAFE0001);

      // RAM never answers: forced completion and sticky error
      dREN = 1'b1; daddr = 32'h304;
      idle_cycle();
      grant_cycles(1'b1, TIMEOUT + 5, 32'h0);
      idle_cycle();
      chk1("err_sticky", err, 1'b1);

      // Reset in the 2nd granted cycle of a slow fetch
      iREN = 1'b1; iaddr = 32'h80;
      idle_cycle();
      ramready = 1'b0;
      @(negedge CLK);
      chk1("mr_ren1", ramREN, 1'b1);
      @(posedge CLK); #3;
      nRST = 1'b0;
      #1;
      err_m = 1'b0;
      chk_quiet("mrst");
      @(negedge CLK);
      nRST = 1'b1;
      @(posedge CLK); #1;
      grant_cycles(1'b0, 5, 32'h55AA55AA);

      // Randomized request mixes and latencies
      for (int n = 0; n < 40; n++) begin
         r      = 3'($urandom_range(1, 7));
         iREN   = r[0];
         dREN   = r[1];
         dWEN   = r[2];
         iaddr  = $urandom;
         daddr  = $urandom;
         dstore = $urandom;
         lat_d  = $urandom_range(1, TIMEOUT + 2);
         lat_i  = $urandom_range(1, TIMEOUT + 2);
         idle_cycle();
         if (r[1] || r[2]) begin
            grant_cycles(1'b1, lat_d, $urandom);
            if (r[0]) idle_cycle();
         end
         if (r[0]) grant_cycles(1'b0, lat_i, $urandom);
      end
      idle_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
